riscv_axi_slave_mem: RTL
========================

Name: riscv_axi_slave_mem

Overview:
AXI4-Lite responder (slave) exposing a word-organised, byte-strobed on-chip memory. It is the target end of the CPU's AXI4-Lite master bus port. It serves instruction/data tests and scratch RAM for the RISC-V core. Write and read channels are independent, with one outstanding transaction each.

Parameters:
MEM_WORDS, 1024, number of 32-bit words; power of two, ≥2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*4.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  32  write address (byte)
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes; bit i enables WDATA[8i+7:8i]
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address (byte)
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0. BRESP, RRESP and RDATA are 0. Write FSM goes to W_COLLECT; read FSM goes to R_IDLE.
- First cycle after reset release: AWREADY, WREADY and ARREADY are set to 1.
- Memory contents are not reset.
- Address decode: off = ADDR - BASE_ADDR. In range iff off < MEM_WORDS*4. Word index = off[log2(MEM_WORDS)+1:2]. ADDR[1:0] is ignored.
- Response codes: OKAY = 2'b00 when in range; DECERR = 2'b11 when out of range.
- Write FSM, state W_COLLECT:
  - AW and W are accepted independently. A handshake (VALID && READY) captures the address or data+strobe into a holding register and drops the matching READY.
  - On the edge where both are held or handshaking (including same-cycle AW+W), the write commits.
  - In range: only strobed bytes are written. Out of range: memory is untouched.
  - At that same edge: BVALID <= 1, BRESP set, AWREADY = WREADY = 0, next state W_RESP.
- Write FSM, state W_RESP:
  - BVALID and BRESP are held stable until BREADY.
  - On the B handshake edge: BVALID <= 0, AWREADY <= 1, WREADY <= 1, holding registers cleared, next state W_COLLECT.
- Write latency: AW+W handshake at edge N gives BVALID high in cycle N+1. Minimum 2 cycles per write when BREADY is held high.
- WSTRB = 4'b0000 completes with OKAY and modifies nothing.
- Read FSM, state R_IDLE (ARREADY = 1):
  - On the AR handshake edge: ARREADY <= 0, RVALID <= 1.
  - RDATA <= mem[idx] in range, or 32'h0 out of range. RRESP is set accordingly.
  - Next state R_RESP.
- Read FSM, state R_RESP:
  - RDATA, RRESP and RVALID are held stable until RREADY.
  - On the handshake edge: RVALID <= 0, ARREADY <= 1, next state R_IDLE.
- Read latency: RVALID is high in the cycle after the AR handshake.
- Read/write collision: a write commit and a read sample on the same edge to the same word returns the pre-write data (read-before-write). The write still commits.
- Channel independence: read and write FSMs never stall each other.
- Reset mid-operation: outstanding B and R responses are abandoned and holding registers cleared. A write commits atomically in one edge, so memory is never half-written.
- Handshake rules:
  - No combinational path exists from any input to any output.
  - VALID is never dropped before its handshake.
  - READY may be low while the matching VALID is high.

Decomposition:
- Shared package riscv_axi_pkg contains:
  - Response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - Write-FSM state encodings W_COLLECT and W_RESP.
  - Read-FSM state encodings R_IDLE and R_RESP.
- One sub-module, riscv_axi_sram: single-clock memory with a synchronous 4-bit byte-enable write port and a synchronous read port with read-before-write semantics. This is the future SRAM macro swap point.

Test Plan:
- Same-cycle write: AW 0x10 and W 0xDEADBEEF with strobe 4'hF in one cycle, BREADY = 1 → BVALID in the next cycle with BRESP = 00. Then AR 0x10 → RVALID one cycle after AR, RDATA = 0xDEADBEEF, RRESP = 00.
- W before AW: W 0x000000AA, strobe 4'b0001, presented 3 cycles before AW 0x10 → WREADY drops after the W handshake and AW is accepted later. Readback = 0xDEADBEAA.
- Out of range: AW 0x1000 with MEM_WORDS = 1024 → BRESP = 11 and memory unchanged. AR 0x1000 → RRESP = 11, RDATA = 0.
- Backpressure: BREADY and RREADY held low for 5 cycles → BVALID/BRESP and RVALID/RDATA stay stable, and AWREADY/ARREADY stay 0 until the handshake.
- Collision: word 0x20 holds 0x11111111. Write 0x22222222 committing on the same edge as the AR to 0x20 → RDATA = 0x11111111. A following read returns 0x22222222.
- Reset mid-transaction: assert rst while BVALID = 1 and while RVALID = 1 → both drop immediately and all READYs are 0. First cycle after release: AWREADY = WREADY = ARREADY = 1.

Source files
------------

// File: rtl/riscv_axi_pkg.sv
// riscv_axi_pkg: shared AXI4-Lite response codes, FSM state types and decode helper
package riscv_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    function automatic logic [1:0] resp_code(input logic in_range);
        return in_range ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/riscv_axi_sram.sv
// riscv_axi_sram: single-clock word memory, byte-enable write port, read-before-write read port
module riscv_axi_sram #(
    parameter int WORDS = 1024,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Byte-masked write and registered read; a same-edge read sees the old word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/riscv_axi_slave_mem.sv
// riscv_axi_slave_mem: AXI4-Lite slave over a byte-strobed word memory with independent read/write FSMs
module riscv_axi_slave_mem
    import riscv_axi_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int          IW   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    wstate_t     w_state, w_next;
    rstate_t     r_state, r_next;

    logic        aw_held, aw_held_n, w_held, w_held_n;
    logic [31:0] awaddr_q, awaddr_n, wdata_q, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
    logic [1:0]  bresp_n, rresp_n;
    logic        rd_ok, rd_ok_n;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] w_addr, w_dat, w_off, r_off;
    logic [3:0]  w_stb;
    logic        w_ok, r_ok;
    logic [31:0] sram_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (w_state == W_COLLECT) && (aw_held || aw_hs) && (w_held || w_hs);

    // A live handshake takes priority over the holding register so same-cycle AW+W commits at once
    assign w_addr = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign w_dat  = w_hs ? S_AXI_WDATA : wdata_q;
    assign w_stb  = w_hs ? S_AXI_WSTRB : wstrb_q;

    assign w_off = w_addr - BASE_ADDR;
    assign r_off = S_AXI_ARADDR - BASE_ADDR;
    assign w_ok  = {1'b0, w_off} < SPAN;
    assign r_ok  = {1'b0, r_off} < SPAN;

    // Read data is gated to zero for decode errors and straight out of reset
    assign S_AXI_RDATA = rd_ok ? sram_q : 32'h0;

    riscv_axi_sram #(.WORDS(MEM_WORDS), .IW(IW)) u_sram (
        .clk   (clk),
        .we    (commit && w_ok),
        .be    (w_stb),
        .waddr (w_off[IW+1:2]),
        .wdata (w_dat),
        .re    (ar_hs),
        .raddr (r_off[IW+1:2]),
        .rdata (sram_q)
    );

    // Write FSM next state: collect AW and W in any order, commit when both present, then hold B
    always_comb begin
        w_next    = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        awaddr_n  = awaddr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awready_n = S_AXI_AWREADY;
        wready_n  = S_AXI_WREADY;
        bvalid_n  = S_AXI_BVALID;
        bresp_n   = S_AXI_BRESP;
        if (w_state == W_COLLECT) begin
            awready_n = !aw_held;
            wready_n  = !w_held;
            if (aw_hs) begin
                aw_held_n = 1'b1;
                awaddr_n  = S_AXI_AWADDR;
                awready_n = 1'b0;
            end
            if (w_hs) begin
                w_held_n = 1'b1;
                wdata_n  = S_AXI_WDATA;
                wstrb_n  = S_AXI_WSTRB;
                wready_n = 1'b0;
            end
            if (commit) begin
                bvalid_n  = 1'b1;
                bresp_n   = resp_code(w_ok);
                awready_n = 1'b0;
                wready_n  = 1'b0;
                w_next    = W_RESP;
            end
        end else if (S_AXI_BREADY) begin
            bvalid_n  = 1'b0;
            awready_n = 1'b1;
            wready_n  = 1'b1;
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            awaddr_n  = 32'h0;
            wdata_n   = 32'h0;
            wstrb_n   = 4'h0;
            w_next    = W_COLLECT;
        end
    end

    // Write FSM state and registered write-channel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_COLLECT;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= 32'h0;
            wdata_q       <= 32'h0;
            wstrb_q       <= 4'h0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            w_state       <= w_next;
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            awaddr_q      <= awaddr_n;
            wdata_q       <= wdata_n;
            wstrb_q       <= wstrb_n;
            S_AXI_AWREADY <= awready_n;
            S_AXI_WREADY  <= wready_n;
            S_AXI_BVALID  <= bvalid_n;
            S_AXI_BRESP   <= bresp_n;
        end
    end

    // Read FSM next state: accept AR when idle, hold R until RREADY
    always_comb begin
        r_next    = r_state;
        arready_n = S_AXI_ARREADY;
        rvalid_n  = S_AXI_RVALID;
        rresp_n   = S_AXI_RRESP;
        rd_ok_n   = rd_ok;
        if (r_state == R_IDLE) begin
            arready_n = !ar_hs;
            if (ar_hs) begin
                rvalid_n = 1'b1;
                rresp_n  = resp_code(r_ok);
                rd_ok_n  = r_ok;
                r_next   = R_RESP;
            end
        end else if (S_AXI_RREADY) begin
            rvalid_n  = 1'b0;
            arready_n = 1'b1;
            r_next    = R_IDLE;
        end
    end

    // Read FSM state and registered read-channel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            rd_ok         <= 1'b0;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= arready_n;
            S_AXI_RVALID  <= rvalid_n;
            S_AXI_RRESP   <= rresp_n;
            rd_ok         <= rd_ok_n;
        end
    end

endmodule
